cpu_sequencer: RTL and testbench

Multi-cycle control and state block for the Simple CPU. It holds PC, IR, ACC, operand register and C/Z flags, and fetches 8-bit instructions over a ready-handshaked memory port. It drives the ALU's a/b/op inputs and consumes the ALU's dout/carry/zero outputs, so it sits both upstream and downstream of the ALU.

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control/state block of the Simple CPU: fetches 8-bit instructions over a
// ready-handshaked memory port, sequences the external ALU and holds PC/IR/ACC/OPR/C/Z.
module cpu_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [4:0]        alu_op,
    input  logic [7:0]        alu_dout,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_AND    = 5'b00001;
    localparam logic [4:0] ALU_PASS_A = 5'b00010;
    localparam logic [4:0] ALU_PASS_B = 5'b00011;
    localparam logic [4:0] ALU_SUB    = 5'b01100;
    localparam logic [4:0] ALU_INC    = 5'b10100;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        ir, ir_nxt;
    logic [7:0]        acc, acc_nxt;
    logic [7:0]        opr, opr_nxt;
    logic              c_flag, c_nxt;
    logic              z_flag, z_nxt;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;

    assign opcode    = ir[7:4];
    assign ir_addr   = ir[ADDR_W-1:0];
    assign mem_wdata = acc;
    assign alu_a     = acc;
    assign alu_b     = opr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            opr    <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            acc    <= acc_nxt;
            opr    <= opr_nxt;
            c_flag <= c_nxt;
            z_flag <= z_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        acc_nxt   = acc;
        opr_nxt   = opr;
        c_nxt     = c_flag;
        z_nxt     = z_flag;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        alu_op    = ALU_PASS_A;
        halted    = 1'b0;

        case (state)
            S_IDLE: state_nxt = S_FETCH;

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: state_nxt = S_MEM_RD;
                    OP_STA: state_nxt = S_MEM_WR;
                    OP_INC: state_nxt = S_EXEC;
                    OP_JMP: begin
                        pc_nxt    = ir_addr;
                        state_nxt = S_FETCH;
                    end
                    OP_JZ: begin
                        if (z_flag) pc_nxt = ir_addr;
                        state_nxt = S_FETCH;
                    end
                    OP_JC: begin
                        if (c_flag) pc_nxt = ir_addr;
                        state_nxt = S_FETCH;
                    end
                    OP_HLT: state_nxt = S_HALT;
                    default: state_nxt = S_FETCH;
                endcase
            end

            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = ir_addr;
                if (mem_ready) begin
                    opr_nxt   = mem_rdata;
                    state_nxt = S_EXEC;
                end
            end

            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir_addr;
                if (mem_ready) state_nxt = S_FETCH;
            end

            // LDA reaches the accumulator through the ALU as PASS_B so every load also sets flags
            S_EXEC: begin
                case (opcode)
                    OP_LDA:  alu_op = ALU_PASS_B;
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_INC:  alu_op = ALU_INC;
                    default: alu_op = ALU_PASS_A;
                endcase
                acc_nxt   = alu_dout;
                c_nxt     = alu_carry;
                z_nxt     = alu_zero;
                state_nxt = S_FETCH;
            end

            S_HALT: halted = 1'b1;

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: provides ALU and wait-state memory, compares every accepted memory
// access against an instruction-level model, plus table vectors and reset/wrap corner cases.
module tb_cpu_sequencer;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic [7:0]        alu_a, alu_b, alu_dout;
    logic [4:0]        alu_op;
    logic              alu_carry, alu_zero, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .halted(halted)
    );

    logic [8:0] alu_res;
    always_comb begin
        case (alu_op)
            5'b00000: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            5'b00001: alu_res = {1'b0, alu_a & alu_b};
            5'b00011: alu_res = {1'b0, alu_b};
            5'b01100: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            5'b10100: alu_res = {1'b0, alu_a} + 9'd1;
            default:  alu_res = {1'b0, alu_a};
        endcase
    end
    assign alu_dout  = alu_res[7:0];
    assign alu_carry = alu_res[8];
    assign alu_zero  = (alu_res[7:0] == 8'h00);

    // Memory model; each accepted access is logged as {alu_op, we, addr, wdata, alu_a}
    logic [7:0]  mem [16];
    logic [7:0]  init_img [16];
    int          wait_seq [256];
    int          wait_cnt;
    int          acc_idx;
    logic        noise;
    logic [25:0] log_rec [256];

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = mem_req ? (wait_cnt == wait_seq[acc_idx]) : noise;

    always @(negedge clk) noise <= 1'($urandom & 1);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
            wait_cnt <= 0;
            acc_idx  <= 0;
        end else if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            log_rec[acc_idx] <= {alu_op, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00), alu_a};
            if (acc_idx < 255) acc_idx <= acc_idx + 1;
            wait_cnt <= 0;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    logic [25:0] exp_rec [256];
    int          exp_n;
    bit          exp_halt;
    int          exp_cycles;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] acc_init;
        logic [7:0] opr;
        logic [7:0] exp_acc;
        logic [3:0] exp_halt_pc;
    } vec_t;

    vec_t tbl [15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_waits(input int mode);
        for (int k = 0; k < 256; k++)
            wait_seq[k] = (mode == 2) ? int'($urandom_range(0, 3)) : mode;
    endtask

    // Instruction-level model: executes the program and lists the accesses it must perform
    task automatic run_model(input int max_acc);
        int m [16];
        int pc, acc, c, z, ir, op, a, v, r, n;
        n = 0; pc = 0; acc = 0; c = 0; z = 0;
        exp_halt = 0; exp_cycles = 0;
        for (int i = 0; i < 16; i++) m[i] = init_img[i];
        while (!exp_halt && n < max_acc) begin
            exp_rec[n] = {5'b00010, 1'b0, 4'(pc), 8'h00, 8'(acc)};
            n++;
            ir = m[pc]; pc = (pc + 1) % 16; op = ir / 16; a = ir % 16;
            exp_cycles += 2;
            case (op)
                1, 3, 4, 5: begin
                    if (n < max_acc) begin
                        exp_rec[n] = {5'b00010, 1'b0, 4'(a), 8'h00, 8'(acc)};
                        n++;
                    end
                    v = m[a];
                    exp_cycles += 2;
                    r = (op == 1) ? v : (op == 3) ? acc + v : (op == 4) ? acc - v : (acc & v);
                    c = (r > 255 || r < 0) ? 1 : 0;
                    acc = r & 255;
                    z = (acc == 0) ? 1 : 0;
                end
                2: begin
                    if (n < max_acc) begin
                        exp_rec[n] = {5'b00010, 1'b1, 4'(a), 8'(acc), 8'(acc)};
                        n++;
                    end
                    m[a] = acc;
                    exp_cycles += 1;
                end
                6: begin
                    r = acc + 1;
                    c = (r > 255) ? 1 : 0;
                    acc = r & 255;
                    z = (acc == 0) ? 1 : 0;
                    exp_cycles += 1;
                end
                7: pc = a;
                8: if (z != 0) pc = a;
                9: if (c != 0) pc = a;
                15: exp_halt = 1;
                default: ;
            endcase
        end
        exp_n = n;
        for (int k = 0; k < n; k++) exp_cycles += wait_seq[k];
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_program(input string tag, input int wmode, input int max_acc, output int cycles);
        int   cyc, first_req, halt_cyc;
        logic pend, p_we;
        logic [ADDR_W-1:0] p_addr;
        set_waits(wmode);
        run_model(max_acc);
        reset_dut();
        cyc = 0; first_req = -1; halt_cyc = -1; pend = 1'b0; p_we = 1'b0; p_addr = '0;
        while (cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (pend) checkOutput({tag, " hold"}, {30'd0, mem_req, mem_we} << 4 | 32'(mem_addr),
                                  {30'd0, 1'b1, p_we} << 4 | 32'(p_addr));
            pend = mem_req && !mem_ready;
            p_we = mem_we;
            p_addr = mem_addr;
            if (first_req < 0 && mem_req) first_req = cyc;
            if (halted) begin
                halt_cyc = cyc;
                break;
            end
            if (!exp_halt && acc_idx >= exp_n) break;
        end
        checkOutput({tag, " count"}, acc_idx, exp_n);
        for (int k = 0; k < exp_n && k < acc_idx; k++)
            checkOutput($sformatf("%s access%0d", tag, k), 32'(log_rec[k]), 32'(exp_rec[k]));
        cycles = halt_cyc - first_req;
        if (exp_halt) begin
            checkOutput({tag, " halted"}, 32'(halt_cyc >= 0), 1);
            checkOutput({tag, " cycles"}, cycles, exp_cycles);
            checkOutput({tag, " idle"}, first_req, 1);
            repeat (3) @(negedge clk);
            checkOutput({tag, " absorb"}, {30'd0, halted, mem_req}, 32'd2);
        end
    endtask

    task automatic load_alu_program();
        for (int i = 0; i < 16; i++) init_img[i] = 8'h00;
        init_img[0] = 8'h1E; init_img[1] = 8'h3F; init_img[2] = 8'h2D; init_img[3] = 8'hF0;
        init_img[14] = 8'hF0; init_img[15] = 8'h20;
    endtask

    function automatic logic [3:0] last_fetch_addr();
        int idx;
        idx = (acc_idx > 0) ? acc_idx - 1 : 0;
        return log_rec[idx][19:16];
    endfunction

    task automatic applyStimulus(input int idx);
        int cyc;
        for (int i = 0; i < 16; i++) init_img[i] = 8'h00;
        init_img[0] = 8'h1E; init_img[1] = tbl[idx].instr; init_img[2] = 8'h2D;
        init_img[3] = 8'h98; init_img[4] = 8'h8A; init_img[5] = 8'hF0;
        init_img[8] = 8'h8B; init_img[9] = 8'hF0; init_img[10] = 8'hF0; init_img[11] = 8'hF0;
        init_img[14] = tbl[idx].acc_init; init_img[15] = tbl[idx].opr;
        run_program($sformatf("vec%0d", idx), (idx % 2 == 1) ? 2 : 0, 60, cyc);
        checkOutput($sformatf("vec%0d acc", idx), 32'(mem[13]), 32'(tbl[idx].exp_acc));
        checkOutput($sformatf("vec%0d flags", idx), 32'(last_fetch_addr()), 32'(tbl[idx].exp_halt_pc));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bit found;
        tbl[0]  = '{8'h3F, 8'hF0, 8'h20, 8'h10, 4'h9};
        tbl[1]  = '{8'h3F, 8'h80, 8'h80, 8'h00, 4'hB};
        tbl[2]  = '{8'h3F, 8'h12, 8'h34, 8'h46, 4'h5};
        tbl[3]  = '{8'h4F, 8'h05, 8'h05, 8'h00, 4'hA};
        tbl[4]  = '{8'h4F, 8'h09, 8'h05, 8'h04, 4'h5};
        tbl[5]  = '{8'h4F, 8'h05, 8'h09, 8'hFC, 4'h9};
        tbl[6]  = '{8'h5F, 8'hF0, 8'h0F, 8'h00, 4'hA};
        tbl[7]  = '{8'h5F, 8'h3C, 8'h0F, 8'h0C, 4'h5};
        tbl[8]  = '{8'h6F, 8'hFF, 8'h00, 8'h00, 4'hB};
        tbl[9]  = '{8'h6F, 8'h41, 8'h00, 8'h42, 4'h5};
        tbl[10] = '{8'h1F, 8'h77, 8'h00, 8'h00, 4'hA};
        tbl[11] = '{8'h0F, 8'h00, 8'h55, 8'h00, 4'hA};
        tbl[12] = '{8'hBF, 8'h00, 8'h55, 8'h00, 4'hA};
        tbl[13] = '{8'hBF, 8'h5A, 8'h55, 8'h5A, 4'h5};
        tbl[14] = '{8'h2C, 8'h5A, 8'h55, 8'h5A, 4'h5};

        load_alu_program();
        set_waits(0);
        @(negedge clk);
        checkOutput("por mem", {14'd0, mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
        checkOutput("por alu", {10'd0, alu_a, alu_b, alu_op, halted}, {10'd0, 8'h00, 8'h00, 5'b00010, 1'b0});

        run_program("alu0", 0, 60, cyc);
        checkOutput("alu0 mem13", 32'(mem[13]), 32'h10);
        checkOutput("alu0 acc", 32'(alu_a), 32'h10);
        checkOutput("alu0 13cyc", cyc, 13);

        // Asynchronous reset from a halted state with non-zero ACC/OPR
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset mem", {14'd0, mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
        checkOutput("reset alu", {10'd0, alu_a, alu_b, alu_op, halted}, {10'd0, 8'h00, 8'h00, 5'b00010, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("release idle", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("first fetch", {26'd0, mem_req, mem_we, mem_addr}, 32'h20);

        run_program("alu3", 3, 60, cyc);
        checkOutput("alu3 mem13", 32'(mem[13]), 32'h10);
        checkOutput("alu3 acc", 32'(alu_a), 32'h10);
        checkOutput("alu3 cyc", cyc, 34);

        // LDA E; STA 0 turns address 0 into HLT; JMP F runs opcode B then wraps to 0
        for (int i = 0; i < 16; i++) init_img[i] = 8'h00;
        init_img[0] = 8'h1E; init_img[1] = 8'h20; init_img[2] = 8'h7F;
        init_img[14] = 8'hF0; init_img[15] = 8'hB0;
        run_program("wrap", 0, 60, cyc);
        checkOutput("wrap fetchF", 32'(log_rec[5][19:16]), 32'hF);
        checkOutput("wrap fetch0", 32'(log_rec[6][19:16]), 32'h0);
        checkOutput("wrap acc", 32'(log_rec[6][7:0]), 32'hF0);

        // Reset asserted while MEM_RD is waiting for ready
        load_alu_program();
        set_waits(3);
        reset_dut();
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc_idx == 1 && mem_req && mem_addr == 4'hE) begin
                found = 1;
                break;
            end
        end
        checkOutput("memrd reached", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1 checkOutput("abort", {23'd0, mem_req, alu_a}, 32'd0);
        run_program("restart", 3, 60, cyc);
        checkOutput("restart mem13", 32'(mem[13]), 32'h10);

        for (int i = 0; i < 15; i++) applyStimulus(i);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) init_img[i] = 8'($urandom);
            run_program($sformatf("rand%0d", r), 2, 60, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
